// File: rtl/div_result_display.sv
// Captures a divider quotient/remainder pair, converts both to BCD with a
// sequential double-dabble engine, and scans four digits onto a common-anode display.
module div_result_display #(
    parameter int unsigned SCAN_DIV = 4,
    parameter bit          LZ_BLANK = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [4:0] q,
    input  logic [4:0] r,
    output logic       busy,
    output logic       done,
    output logic [3:0] an,
    output logic [6:0] seg
);

    localparam int unsigned BIN_W  = 5;
    localparam int unsigned BCD_W  = 8;
    localparam int unsigned SH_W   = BCD_W + BIN_W;
    localparam int unsigned DIG_W  = 4;
    localparam int unsigned NDIG   = 4;
    localparam int unsigned CNT_W  = 3;
    localparam int unsigned IDX_W  = 2;
    localparam int unsigned SEG_W  = 7;
    localparam int unsigned PRE_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CONV  = 2'd1,
        LATCH = 2'd2
    } state_e;

    state_e                      state_q, state_d;
    logic [BIN_W-1:0]            q_bin_q, q_bin_d, r_bin_q, r_bin_d;
    logic [BCD_W-1:0]            q_bcd_q, q_bcd_d, r_bcd_q, r_bcd_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [NDIG-1:0][DIG_W-1:0]  dig_q, dig_d;
    logic                        busy_q, busy_d;
    logic                        done_q, done_d;
    logic [PRE_W-1:0]            pre_q, pre_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic [NDIG-1:0]             an_q, an_d;
    logic [SEG_W-1:0]            seg_q, seg_d;
    logic [SH_W-1:0]             q_sh, r_sh;
    logic [DIG_W-1:0]            cur_dig;

    // Add 3 to every BCD nibble that is 5 or more, ahead of the shift.
    function automatic logic [BCD_W-1:0] dabble_adj(input logic [BCD_W-1:0] b);
        logic [DIG_W-1:0] lo;
        logic [DIG_W-1:0] hi;
        lo = b[3:0];
        hi = b[7:4];
        if (lo >= DIG_W'(5)) lo = lo + DIG_W'(3);
        if (hi >= DIG_W'(5)) hi = hi + DIG_W'(3);
        return {hi, lo};
    endfunction

    // Active-low segment pattern {g,f,e,d,c,b,a}.
    function automatic logic [SEG_W-1:0] seg_decode(input logic [DIG_W-1:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return SEG_BLANK;
        endcase
    endfunction

    // Capture / convert / latch sequencing.
    always_comb begin
        state_d = state_q;
        q_bin_d = q_bin_q;
        r_bin_d = r_bin_q;
        q_bcd_d = q_bcd_q;
        r_bcd_d = r_bcd_q;
        cnt_d   = cnt_q;
        dig_d   = dig_q;
        done_d  = 1'b0;
        q_sh    = {dabble_adj(q_bcd_q), q_bin_q} << 1;
        r_sh    = {dabble_adj(r_bcd_q), r_bin_q} << 1;

        case (state_q)
            IDLE: begin
                if (load) begin
                    q_bin_d = q;
                    r_bin_d = r;
                    q_bcd_d = '0;
                    r_bcd_d = '0;
                    cnt_d   = '0;
                    state_d = CONV;
                end
            end
            CONV: begin
                q_bcd_d = q_sh[SH_W-1:BIN_W];
                q_bin_d = q_sh[BIN_W-1:0];
                r_bcd_d = r_sh[SH_W-1:BIN_W];
                r_bin_d = r_sh[BIN_W-1:0];
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(BIN_W - 1)) state_d = LATCH;
            end
            LATCH: begin
                dig_d   = {q_bcd_q[7:4], q_bcd_q[3:0], r_bcd_q[7:4], r_bcd_q[3:0]};
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // Free-running digit scan; an/seg registered from the next-state view so
    // a freshly latched digit appears as soon as the index selects it.
    always_comb begin
        pre_d = pre_q + PRE_W'(1);
        idx_d = idx_q;
        if (pre_q == PRE_W'(SCAN_DIV - 1)) begin
            pre_d = '0;
            idx_d = idx_q + IDX_W'(1);
        end
        an_d    = ~(NDIG'(1) << idx_d);
        cur_dig = dig_d[idx_d];
        seg_d   = seg_decode(cur_dig);
        if (LZ_BLANK && idx_d[0] && (cur_dig == '0)) seg_d = SEG_BLANK;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            q_bin_q <= '0;
            r_bin_q <= '0;
            q_bcd_q <= '0;
            r_bcd_q <= '0;
            cnt_q   <= '0;
            dig_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pre_q   <= '0;
            idx_q   <= '0;
            an_q    <= 4'b1110;
            seg_q   <= 7'b1000000;
        end else begin
            state_q <= state_d;
            q_bin_q <= q_bin_d;
            r_bin_q <= r_bin_d;
            q_bcd_q <= q_bcd_d;
            r_bcd_q <= r_bcd_d;
            cnt_q   <= cnt_d;
            dig_q   <= dig_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pre_q   <= pre_d;
            idx_q   <= idx_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign an   = an_q;
    assign seg  = seg_q;

endmodule

// File: tb/tb_div_result_display.sv
// Directed bench for div_result_display: reset/scan, conversion latency,
// dropped loads, mid-conversion reset and leading-zero blanking.
module tb_div_result_display;

    logic       clk = 1'b0;
    logic       reset;
    logic       load;
    logic [4:0] q;
    logic [4:0] r;
    logic       busy0, done0, busy1, done1;
    logic [3:0] an0, an1;
    logic [6:0] seg0, seg1;

    int vectors     = 0;
    int miscompares = 0;
    int done_seen   = 0;
    int first_done;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] SB = 7'b1111111;

    div_result_display #(.SCAN_DIV(4), .LZ_BLANK(1'b0)) dut0 (
        .clk(clk), .reset(reset), .load(load), .q(q), .r(r),
        .busy(busy0), .done(done0), .an(an0), .seg(seg0)
    );

    div_result_display #(.SCAN_DIV(4), .LZ_BLANK(1'b1)) dut1 (
        .clk(clk), .reset(reset), .load(load), .q(q), .r(r),
        .busy(busy1), .done(done1), .an(an1), .seg(seg1)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        if (done0) done_seen++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance until dut0 enables the wanted digit (bounded to two scan periods).
    task automatic wait_an(input logic [3:0] tgt);
        int n = 0;
        while (an0 !== tgt && n < 32) begin
            tick();
            n++;
        end
        chk($sformatf("an_%b", tgt), 32'(an0), 32'(tgt));
    endtask

    task automatic pulse_load(input logic [4:0] qv, input logic [4:0] rv);
        load = 1'b1; q = qv; r = rv;
        tick();
        load = 1'b0;
    endtask

    initial begin
        reset = 1'b1; load = 1'b0; q = '0; r = '0;

        // Reset state and idle scan
        tick();
        reset = 1'b0;
        chk("rst_busy", 32'(busy0), 32'd0);
        chk("rst_done", 32'(done0), 32'd0);
        chk("rst_an",   32'(an0),   32'b1110);
        chk("rst_seg",  32'(seg0),  32'(S0));
        repeat (4) tick();
        chk("idle_an1", 32'(an0), 32'b1101);
        chk("idle_seg1", 32'(seg0), 32'(S0));
        repeat (4) tick();
        chk("idle_an2", 32'(an0), 32'b1011);
        chk("idle_seg2", 32'(seg0), 32'(S0));
        repeat (4) tick();
        chk("idle_an3", 32'(an0), 32'b0111);
        chk("idle_seg3", 32'(seg0), 32'(S0));
        repeat (4) tick();
        chk("idle_an0", 32'(an0), 32'b1110);
        repeat (4) tick();
        chk("idle_busy", 32'(busy0), 32'd0);
        chk("idle_dones", 32'(done_seen), 32'd0);

        // 7/3: q=2 r=1, done exactly 6 cycles after load
        done_seen = 0; first_done = 0;
        pulse_load(5'd2, 5'd1);
        chk("l1_busy", 32'(busy0), 32'd1);
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (done0 && first_done == 0) first_done = i;
        end
        chk("l1_done_lat", 32'(first_done), 32'd6);
        chk("l1_done_cnt", 32'(done_seen), 32'd1);
        chk("l1_busy_end", 32'(busy0), 32'd0);
        wait_an(4'b1110); chk("l1_r1", 32'(seg0), 32'(S1));
        wait_an(4'b1101); chk("l1_r10", 32'(seg0), 32'(S0));
        wait_an(4'b1011); chk("l1_q1", 32'(seg0), 32'(S2));
        wait_an(4'b0111); chk("l1_q10", 32'(seg0), 32'(S0));

        // 31/31 -> digits 1,3,1,3
        done_seen = 0;
        pulse_load(5'd31, 5'd31);
        repeat (7) tick();
        chk("l2_done_cnt", 32'(done_seen), 32'd1);
        wait_an(4'b1101); chk("l2_r10", 32'(seg0), 32'(S3));
        wait_an(4'b1011); chk("l2_q1", 32'(seg0), 32'(S1));
        wait_an(4'b0111); chk("l2_q10", 32'(seg0), 32'(S3));
        wait_an(4'b1110); chk("l2_r1", 32'(seg0), 32'(S1));

        // Loads at +2 (CONV) and +6 (LATCH) are dropped
        done_seen = 0;
        pulse_load(5'd5, 5'd0);            // edge k
        tick();                             // k+1
        pulse_load(5'd9, 5'd0);            // k+2
        repeat (3) tick();                  // k+3..k+5
        pulse_load(5'd9, 5'd0);            // k+6
        chk("l3_done_k6", 32'(done0), 32'd1);
        repeat (10) tick();
        chk("l3_done_cnt", 32'(done_seen), 32'd1);
        chk("l3_busy", 32'(busy0), 32'd0);
        wait_an(4'b1011); chk("l3_q1", 32'(seg0), 32'(S5));
        wait_an(4'b0111); chk("l3_q10", 32'(seg0), 32'(S0));
        wait_an(4'b1110); chk("l3_r1", 32'(seg0), 32'(S0));

        // Reset at +3 aborts conversion and clears the display
        done_seen = 0;
        pulse_load(5'd12, 5'd4);           // k
        repeat (2) tick();                  // k+1, k+2
        reset = 1'b1;
        tick();                             // k+3
        reset = 1'b0;
        chk("l4_busy", 32'(busy0), 32'd0);
        chk("l4_done", 32'(done0), 32'd0);
        chk("l4_an",   32'(an0),   32'b1110);
        chk("l4_seg",  32'(seg0),  32'(S0));
        repeat (8) tick();
        chk("l4_no_done", 32'(done_seen), 32'd0);
        wait_an(4'b1011); chk("l4_q1_clr", 32'(seg0), 32'(S0));
        wait_an(4'b0111); chk("l4_q10_clr", 32'(seg0), 32'(S0));

        // Fresh load after the abort converts normally
        done_seen = 0;
        pulse_load(5'd12, 5'd4);
        repeat (7) tick();
        chk("l5_done_cnt", 32'(done_seen), 32'd1);
        wait_an(4'b1110); chk("l5_r1", 32'(seg0), 32'(S4));
        wait_an(4'b1011); chk("l5_q1", 32'(seg0), 32'(S2));
        wait_an(4'b0111); chk("l5_q10", 32'(seg0), 32'(S1));

        // Leading-zero blanking (dut1) vs plain zero (dut0): q=7 r=10
        pulse_load(5'd7, 5'd10);
        repeat (7) tick();
        wait_an(4'b0111);
        chk("lz_an1", 32'(an1), 32'b0111);
        chk("lz_q10_blank", 32'(seg1), 32'(SB));
        chk("nolz_q10", 32'(seg0), 32'(S0));
        wait_an(4'b1110);
        chk("lz_r1", 32'(seg1), 32'(S0));
        wait_an(4'b1101);
        chk("lz_r10", 32'(seg1), 32'(S1));
        wait_an(4'b1011);
        chk("lz_q1", 32'(seg1), 32'(S7));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
